rob: RTL

- Reorder buffer for the out-of-order MIPS core.
- Sits directly upstream of the register status table (RST):
  - hands each dispatched instruction a 5-bit tag, which dispatch writes into the RST as Wdata.
  - retires instructions in program order, broadcasting the retired tag/valid pair that the RST consumes as RB_tag/RB_valid.
- Also holds speculative results and serves operand look-ups for tags the RST reports as pending.

---
 rtl/rob_pkg.sv | 18 +
 rtl/rob_ptr.sv | 46 ++++
 rtl/rob.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared types and sizing.
// Entry layout used by the ROB storage array.
package rob_pkg;

    localparam int DEPTH  = 32;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              wr_reg;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit head/tail pointer pair with registered occupancy.
// The extra MSB distinguishes full from empty at equal indices.
module rob_ptr
    import rob_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_head,
    input  logic             inc_tail,
    input  logic             clear,
    output logic [TAG_W-1:0] head_idx,
    output logic [TAG_W-1:0] tail_idx,
    output logic             full,
    output logic             empty,
    output logic [TAG_W:0]   count
);

    logic [TAG_W:0] head;
    logic [TAG_W:0] tail;

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (inc_head) head <= head + 1'b1;
            if (inc_tail) tail <= tail + 1'b1;
            unique case ({inc_tail, inc_head})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order retire of out-of-order results,
// tag allocation for the RST and operand look-up with CDB forwarding.
module rob
    import rob_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [REG_W-1:0]  disp_rd_addr,
    input  logic              disp_wr_reg,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [TAG_W-1:0]  rs_tag,
    output logic              rs_ready,
    output logic [DATA_W-1:0] rs_data,
    input  logic [TAG_W-1:0]  rt_tag,
    output logic              rt_ready,
    output logic [DATA_W-1:0] rt_data,
    output logic              cmt_valid,
    output logic [TAG_W-1:0]  cmt_tag,
    output logic              cmt_wr_reg,
    output logic [REG_W-1:0]  cmt_rd_addr,
    output logic [DATA_W-1:0] cmt_data,
    input  logic              flush,
    output logic [TAG_W:0]    count
);

    rob_entry_t ent [DEPTH];

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             empty;
    logic             do_disp;
    logic             do_cmt;
    logic             do_cdb;

    assign disp_ready = !full;
    assign disp_tag   = tail_idx;
    assign do_disp    = disp_valid && !full && !flush;
    assign do_cmt     = !empty && ent[head_idx].done && !flush;
    assign do_cdb     = cdb_valid && ent[cdb_tag].busy && !flush;

    rob_ptr u_ptr (
        .clock    (clock),
        .reset    (reset),
        .inc_head (do_cmt),
        .inc_tail (do_disp),
        .clear    (flush),
        .head_idx (head_idx),
        .tail_idx (tail_idx),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Later assignments win: a commit retires the head even if the CDB hits it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].busy <= 1'b0;
                ent[i].done <= 1'b0;
            end
        end else begin
            if (do_cdb) begin
                ent[cdb_tag].data <= cdb_data;
                ent[cdb_tag].done <= 1'b1;
            end
            if (do_cmt) begin
                ent[head_idx].busy <= 1'b0;
                ent[head_idx].done <= 1'b0;
            end
            if (do_disp) begin
                ent[tail_idx].busy   <= 1'b1;
                ent[tail_idx].done   <= 1'b0;
                ent[tail_idx].wr_reg <= disp_wr_reg;
                ent[tail_idx].rd     <= disp_rd_addr;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmt_valid   <= 1'b0;
            cmt_tag     <= '0;
            cmt_wr_reg  <= 1'b0;
            cmt_rd_addr <= '0;
            cmt_data    <= '0;
        end else if (do_cmt) begin
            cmt_valid   <= 1'b1;
            cmt_tag     <= head_idx;
            cmt_wr_reg  <= ent[head_idx].wr_reg;
            cmt_rd_addr <= ent[head_idx].rd;
            cmt_data    <= ent[head_idx].data;
        end else begin
            cmt_valid   <= 1'b0;
        end
    end

    always_comb begin
        rs_ready = ent[rs_tag].busy && ent[rs_tag].done;
        rs_data  = ent[rs_tag].data;
        if (cdb_valid && cdb_tag == rs_tag && ent[rs_tag].busy) begin
            rs_ready = 1'b1;
            rs_data  = cdb_data;
        end
    end

    always_comb begin
        rt_ready = ent[rt_tag].busy && ent[rt_tag].done;
        rt_data  = ent[rt_tag].data;
        if (cdb_valid && cdb_tag == rt_tag && ent[rt_tag].busy) begin
            rt_ready = 1'b1;
            rt_data  = cdb_data;
        end
    end

endmodule
